// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, response record and byte-masked write merge
package wb_pkg;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;
  typedef struct packed {
    logic                     valid;
    logic                     err;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_resp_t;
  function automatic logic [WB_DATA_WIDTH-1:0] sel_merge(
    input logic [WB_DATA_WIDTH-1:0] old_w,
    input logic [WB_DATA_WIDTH-1:0] new_w,
    input logic [WB_SEL_WIDTH-1:0]  sel
  );
    logic [WB_DATA_WIDTH-1:0] r;
    for (int n = 0; n < WB_SEL_WIDTH; n++) r[8*n +: 8] = sel[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wb_response_pipe.sv
// wb_response_pipe: LATENCY-deep response shift (i_resp in, o_resp out after LATENCY edges; i_rst/i_flush clear all entries)
module wb_response_pipe
  import wb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_flush,
  input  wb_resp_t i_resp,
  output wb_resp_t o_resp
);
  wb_resp_t [LATENCY-1:0] r_pipe;
  always_ff @(posedge i_clk) begin
    if (i_rst | i_flush) r_pipe <= '0;
    else begin
      r_pipe[0] <= i_resp;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_resp = r_pipe[LATENCY-1];
endmodule

// File: rtl/wb_pipelined_memory_responder.sv
// wb_pipelined_memory_responder: pipelined Wishbone word memory (cyc/stb/we/sel/addr/data_i in; data_o/ack_o/err_o/stall_o out, fixed LATENCY, MAX_OUTSTANDING limit)
module wb_pipelined_memory_responder
  import wb_pkg::*;
#(
  parameter int    MEMORY_SIZE     = 4096,
  parameter int    LATENCY         = 2,
  parameter int    MAX_OUTSTANDING = 2,
  parameter string MEMORY_FILE     = ""
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_SEL_WIDTH-1:0]  sel_i,
  input  logic [WB_ADDR_WIDTH-1:0] addr_i,
  input  logic [WB_DATA_WIDTH-1:0] data_i,
  output logic [WB_DATA_WIDTH-1:0] data_o,
  output logic                     ack_o,
  output logic                     err_o,
  output logic                     stall_o
);
  localparam int AW = $clog2(MEMORY_SIZE);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  logic [WB_DATA_WIDTH-1:0] r_mem [MEMORY_SIZE/4];
  logic [CW-1:0]            r_cnt;
  logic [AW-3:0]            w_idx;
  logic                     w_in_range;
  logic                     w_accept;
  logic                     w_done;
  wb_resp_t                 w_in;
  wb_resp_t                 w_out;
  assign w_idx      = addr_i[AW-1:2];
  assign w_in_range = addr_i < WB_ADDR_WIDTH'(MEMORY_SIZE);
  assign w_done     = cyc_i & w_out.valid;
  assign ack_o      = w_done & ~w_out.err;
  assign err_o      = w_done & w_out.err;
  assign data_o     = w_done ? w_out.data : '0;
  assign stall_o    = (r_cnt == MAX_CNT) & ~w_done;
  assign w_accept   = cyc_i & stb_i & ~stall_o;
  assign w_in       = '{valid: w_accept, err: ~w_in_range, data: (~we_i & w_in_range) ? r_mem[w_idx] : '0};
  wb_response_pipe #(.LATENCY(LATENCY)) u_pipe (
    .i_clk  (clk_core),
    .i_rst  (rst_core),
    .i_flush(~cyc_i),
    .i_resp (w_in),
    .o_resp (w_out)
  );
  always_ff @(posedge clk_core) begin
    if (~rst_core & w_accept & we_i & w_in_range) r_mem[w_idx] <= sel_merge(r_mem[w_idx], data_i, sel_i);
  end
  always_ff @(posedge clk_core) begin
    if (rst_core | ~cyc_i) r_cnt <= '0;
    else if (w_accept & ~w_done) r_cnt <= r_cnt + 1'b1;
    else if (~w_accept & w_done) r_cnt <= r_cnt - 1'b1;
  end
  always_ff @(posedge clk_core) begin
    if (~rst_core & cyc_i) begin
      assert (!(w_accept && !w_done && r_cnt == MAX_CNT));
      assert (!(w_done && !w_accept && r_cnt == '0));
    end
  end
endmodule
